// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU that pushes one operand bit per clock, LSB first,
// through a single full-adder/logic slice with a registered carry. Results,
// carry-out, zero and error flags update only when an operation completes.
module serial_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       M,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             next,
   output logic             zero,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [7:0] MODE_ADD  = 8'h01;
   localparam logic [7:0] MODE_AND  = 8'h02;
   localparam logic [7:0] MODE_OR   = 8'h04;
   localparam logic [7:0] MODE_XOR  = 8'h08;
   localparam logic [7:0] MODE_XNOR = 8'h10;
   localparam logic [7:0] MODE_SUB  = 8'h20;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-2:0] res_q;
   logic [7:0]       mode_q;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             is_add;
   logic             is_sub;
   logic             legal;
   logic             b_bit;
   logic             res_bit;
   logic             carry_out;
   logic [WIDTH-1:0] res_full;

   // Mode decode plus the one-bit slice; subtraction is A + ~B + ~borrow
   always_comb begin
      is_add    = (mode_q == MODE_ADD);
      is_sub    = (mode_q == MODE_SUB);
      legal     = is_add || is_sub || (mode_q == MODE_AND) || (mode_q == MODE_OR) ||
                  (mode_q == MODE_XOR) || (mode_q == MODE_XNOR);
      b_bit     = is_sub ? ~b_q[0] : b_q[0];
      carry_out = (a_q[0] & b_bit) | (a_q[0] & carry) | (b_bit & carry);
      res_bit   = 1'b0;
      if (is_add || is_sub) begin
         res_bit = a_q[0] ^ b_bit ^ carry;
      end else if (mode_q == MODE_AND) begin
         res_bit = a_q[0] & b_q[0];
      end else if (mode_q == MODE_OR) begin
         res_bit = a_q[0] | b_q[0];
      end else if (mode_q == MODE_XOR) begin
         res_bit = a_q[0] ^ b_q[0];
      end else if (mode_q == MODE_XNOR) begin
         res_bit = ~(a_q[0] ^ b_q[0]);
      end
      res_full = {res_bit, res_q};
   end

   // Control FSM, operand shifters and registered result/flag outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         mode_q <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         out    <= '0;
         next   <= 1'b0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= M;
                  cnt    <= '0;
                  carry  <= (M == MODE_SUB) ? ~c : c;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= res_full[WIDTH-1:1];
               cnt   <= cnt + CW'(1);
               if (is_add || is_sub) begin
                  carry <= carry_out;
               end
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (legal) begin
                     out  <= res_full;
                     next <= (is_add || is_sub) ? carry_out : 1'b0;
                     zero <= (res_full == '0);
                     err  <= 1'b0;
                  end else begin
                     out  <= '0;
                     next <= 1'b0;
                     zero <= 1'b1;
                     err  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed bench for serial_alu at WIDTH 8, 4 and 16. Expected
// results come from an integer-arithmetic model, are queued when an operation
// is launched and popped when the DUT raises done.
module tb_serial_alu;

   typedef struct {
      logic [63:0] out;
      logic        nxt;
      logic        zero;
      logic        err;
   } exp_t;

   typedef struct {
      logic [63:0] out;
      logic        nxt;
      logic        zero;
      logic        err;
      logic        busy;
      logic        done;
   } obs_t;

   logic clk = 1'b0;
   logic rst;

   logic start8, c8, busy8, done8, next8, zero8, err8;
   logic [7:0] m8, a8, b8, out8;
   logic start4, c4, busy4, done4, next4, zero4, err4;
   logic [7:0] m4;
   logic [3:0] a4, b4, out4;
   logic start16, c16, busy16, done16, next16, zero16, err16;
   logic [7:0] m16;
   logic [15:0] a16, b16, out16;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   serial_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .M(m8), .a(a8), .b(b8), .c(c8),
      .busy(busy8), .done(done8), .out(out8), .next(next8), .zero(zero8), .err(err8)
   );

   serial_alu #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .M(m4), .a(a4), .b(b4), .c(c4),
      .busy(busy4), .done(done4), .out(out4), .next(next4), .zero(zero4), .err(err4)
   );

   serial_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .M(m16), .a(a16), .b(b16), .c(c16),
      .busy(busy16), .done(done16), .out(out16), .next(next16), .zero(zero16), .err(err16)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic c, input logic [7:0] m);
      exp_t r;
      logic [64:0] mask;
      logic [64:0] s;
      mask = (65'd1 << w) - 65'd1;
      s    = '0;
      r.err = 1'b0;
      r.nxt = 1'b0;
      r.out = '0;
      case (m)
         8'h01: begin
            s = {1'b0, a} + {1'b0, b} + {64'd0, c};
            r.out = s[63:0] & mask[63:0];
            r.nxt = s[w];
         end
         8'h20: begin
            s = {1'b0, a} - {1'b0, b} - {64'd0, c};
            r.out = s[63:0] & mask[63:0];
            r.nxt = ~s[w];
         end
         8'h02: r.out = (a & b) & mask[63:0];
         8'h04: r.out = (a | b) & mask[63:0];
         8'h08: r.out = (a ^ b) & mask[63:0];
         8'h10: r.out = ~(a ^ b) & mask[63:0];
         default: r.err = 1'b1;
      endcase
      r.zero = r.err ? 1'b1 : (r.out == 64'd0);
      return r;
   endfunction

   task automatic driveIn(input int w, input logic st, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic [7:0] m);
      case (w)
         4:  begin start4  = st; a4  = a[3:0];  b4  = b[3:0];  c4  = c; m4  = m; end
         16: begin start16 = st; a16 = a[15:0]; b16 = b[15:0]; c16 = c; m16 = m; end
         default: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; c8 = c; m8 = m; end
      endcase
   endtask

   function automatic obs_t observe(input int w);
      obs_t o;
      case (w)
         4:  begin o.out = {60'd0, out4}; o.nxt = next4; o.zero = zero4; o.err = err4;
                   o.busy = busy4; o.done = done4; end
         16: begin o.out = {48'd0, out16}; o.nxt = next16; o.zero = zero16; o.err = err16;
                   o.busy = busy16; o.done = done16; end
         default: begin o.out = {56'd0, out8}; o.nxt = next8; o.zero = zero8; o.err = err8;
                   o.busy = busy8; o.done = done8; end
      endcase
      return o;
   endfunction

   // Drive one start cycle (optionally queueing its expected result) and
   // scramble the inputs afterwards since they are don't-care
   task automatic applyStimulus(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic c, input logic [7:0] m, input bit push);
      obs_t o;
      @(negedge clk);
      if (push) sb.push_back(model(w, a, b, c, m));
      driveIn(w, 1'b1, a, b, c, m);
      @(posedge clk);
      #1;
      o = observe(w);
      checkOutput("busy_after_start", {63'd0, o.busy}, 64'd1);
      @(negedge clk);
      driveIn(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 8'($urandom));
   endtask

   task automatic waitDone(input int w, input int lat, input string tag);
      obs_t o;
      obs_t pre;
      exp_t e;
      int cycles;
      pre = observe(w);
      cycles = 0;
      o = pre;
      while (cycles < lat + 20) begin
         @(posedge clk);
         #1;
         cycles++;
         o = observe(w);
         if (o.done) break;
         if (cycles == lat / 2) checkOutput({tag, ".out_stable"}, o.out, pre.out);
      end
      checkOutput({tag, ".latency"}, 64'(cycles), 64'(lat));
      checkOutput({tag, ".busy_at_done"}, {63'd0, o.busy}, 64'd0);
      if (sb.size() == 0) begin
         checkOutput({tag, ".scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, ".out"},  o.out, e.out);
         checkOutput({tag, ".next"}, {63'd0, o.nxt},  {63'd0, e.nxt});
         checkOutput({tag, ".zero"}, {63'd0, o.zero}, {63'd0, e.zero});
         checkOutput({tag, ".err"},  {63'd0, o.err},  {63'd0, e.err});
      end
   endtask

   task automatic countDones(input int w, input int n, input string tag);
      obs_t o;
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         o = observe(w);
         if (o.done) seen++;
      end
      checkOutput(tag, 64'(seen), 64'd0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence
   initial begin
      obs_t o;
      rst = 1'b1;
      driveIn(8, 1'b0, 0, 0, 1'b0, 8'h00);
      driveIn(4, 1'b0, 0, 0, 1'b0, 8'h00);
      driveIn(16, 1'b0, 0, 0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      o = observe(8);
      checkOutput("reset.busy", {63'd0, o.busy}, 64'd0);
      checkOutput("reset.done", {63'd0, o.done}, 64'd0);
      checkOutput("reset.out",  o.out, 64'd0);
      checkOutput("reset.next", {63'd0, o.nxt},  64'd0);
      checkOutput("reset.zero", {63'd0, o.zero}, 64'd0);
      checkOutput("reset.err",  {63'd0, o.err},  64'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8, 64'h5A, 64'h3C, 1'b0, 8'h01, 1); waitDone(8, 8, "add_5a_3c");
      @(posedge clk);
      #1;
      o = observe(8);
      checkOutput("done_drops", {63'd0, o.done}, 64'd0);
      applyStimulus(8, 64'hFF, 64'h01, 1'b1, 8'h01, 1); waitDone(8, 8, "add_ff_01_c");
      applyStimulus(8, 64'h10, 64'h20, 1'b0, 8'h20, 1); waitDone(8, 8, "sub_10_20");
      applyStimulus(8, 64'h20, 64'h20, 1'b0, 8'h20, 1); waitDone(8, 8, "sub_20_20");
      applyStimulus(8, 64'h20, 64'h10, 1'b1, 8'h20, 1); waitDone(8, 8, "sub_20_10_b");
      applyStimulus(8, 64'hCC, 64'hAA, 1'b1, 8'h02, 1); waitDone(8, 8, "and");
      applyStimulus(8, 64'hCC, 64'hAA, 1'b1, 8'h04, 1); waitDone(8, 8, "or");
      applyStimulus(8, 64'hCC, 64'hAA, 1'b0, 8'h08, 1); waitDone(8, 8, "xor");
      applyStimulus(8, 64'hCC, 64'hAA, 1'b0, 8'h10, 1); waitDone(8, 8, "xnor");
      applyStimulus(8, 64'h12, 64'h34, 1'b1, 8'h03, 1); waitDone(8, 8, "illegal_03");
      applyStimulus(8, 64'h12, 64'h34, 1'b0, 8'h00, 1); waitDone(8, 8, "illegal_00");
      applyStimulus(8, 64'hFF, 64'h01, 1'b1, 8'h80, 1); waitDone(8, 8, "illegal_80");
      applyStimulus(8, 64'h81, 64'h02, 1'b0, 8'h01, 1); waitDone(8, 8, "legal_clears_err");

      // start pulsed while running must be ignored
      applyStimulus(8, 64'h12, 64'h34, 1'b0, 8'h01, 1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b1, 64'hFF, 64'hFF, 1'b1, 8'h20);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b0, 0, 0, 1'b0, 8'h00);
      waitDone(8, 5, "start_in_run");
      countDones(8, 12, "no_extra_done");

      // Back-to-back: second start sampled in the DONE cycle
      applyStimulus(8, 64'h0F, 64'h0F, 1'b0, 8'h01, 1); waitDone(8, 8, "b2b_first");
      applyStimulus(8, 64'h33, 64'h11, 1'b0, 8'h20, 1); waitDone(8, 8, "b2b_second");

      // Reset three cycles into an operation aborts it
      applyStimulus(8, 64'h5A, 64'h3C, 1'b0, 8'h01, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      o = observe(8);
      checkOutput("abort.busy", {63'd0, o.busy}, 64'd0);
      checkOutput("abort.done", {63'd0, o.done}, 64'd0);
      checkOutput("abort.out",  o.out, 64'd0);
      checkOutput("abort.zero", {63'd0, o.zero}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      countDones(8, 12, "abort.no_done");
      applyStimulus(8, 64'h5A, 64'h3C, 1'b0, 8'h01, 1); waitDone(8, 8, "after_abort");

      // Other widths
      applyStimulus(4, 64'hF, 64'h1, 1'b0, 8'h01, 1);    waitDone(4, 4, "w4_add");
      applyStimulus(4, 64'h3, 64'h5, 1'b0, 8'h20, 1);    waitDone(4, 4, "w4_sub");
      applyStimulus(16, 64'hF, 64'h1, 1'b0, 8'h01, 1);   waitDone(16, 16, "w16_add");
      applyStimulus(16, 64'hFFFF, 64'h1, 1'b0, 8'h01, 1); waitDone(16, 16, "w16_wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
